serial_byte_assembler: RTL and testbench
========================================

# serial_byte_assembler

Collects a bit-serial stream into WIDTH-bit parallel words and presents each finished word to the downstream stage through a valid/ready handshake. It sits directly upstream of the 8-bit bit-order reversal stage, which consumes byte_out. A one-word output holding register lets the next word accumulate while the previous word waits for acceptance. Stalls are pushed back to the serial source through bit_ready.

## Interface
- WIDTH, 8: word width in bits, legal range 2..32.
- MSB_FIRST, 0: bit order. 0 places the first received bit in byte_out[0]. 1 places it in byte_out[WIDTH-1].

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- frame_start  input  1  qualifies the current bit as bit 0 of a new word.
- bit_ready  output  1  block accepts the serial bit this cycle.
- byte_out  output  WIDTH  assembled word, registered.
- byte_valid  output  1  byte_out holds an unaccepted word.
- byte_ready  input  1  downstream accepts byte_out this cycle.
- drop_cnt  output  8  saturating count of partial words discarded by frame_start.

## Operation
- Bit accept: bit_valid && bit_ready.
- Word accept: byte_valid && byte_ready.
- State:
  - shift register sr[WIDTH-1:0].
  - bit counter cnt, range 0..WIDTH-1.
  - output register byte_out with flag byte_valid.
- On bit accept, the bit is written at index cnt (MSB_FIRST=0) or index WIDTH-1-cnt (MSB_FIRST=1).
- On bit accept with cnt < WIDTH-1: cnt increments.
- On bit accept with cnt == WIDTH-1 (word complete):
  - The completed word (sr with the new bit merged) loads byte_out.
  - byte_valid is set and cnt wraps to 0.
- On frame_start with bit accept:
  - If cnt != 0, the partial word is discarded and drop_cnt increments, saturating at 255.
  - The bit is written as bit 0 and cnt becomes 1.
  - With WIDTH bits already held (cnt==0 after a wrap), nothing is dropped.
- frame_start without bit_valid is ignored.
- bit_ready = !rst && (cnt != WIDTH-1 || !byte_valid || byte_ready).
  - A completing bit is accepted only if the output register is empty or is being drained in the same cycle.
  - bit_ready has a combinational path from byte_ready; no other input-to-output combinational paths exist.
- On word accept without a completing bit, byte_valid clears.
- Simultaneous word accept and completing bit: byte_out loads the new word and byte_valid stays 1.
- byte_out holds its value after acceptance; only byte_valid clears. It changes only on a word load.
- A non-completing bit with cnt < WIDTH-1 is always accepted, regardless of byte_valid.

## Timing
- Reset (rst high at an edge):
  - cnt=0, sr=0, byte_out=0, byte_valid=0, drop_cnt=0.
  - bit_ready is 0 while rst is high; inputs are ignored.
- Reset mid-word or with a pending word: all state is discarded with no drop count. First bit after reset is bit 0.
- Latency: byte_valid asserts in the cycle after the edge that accepted the WIDTH-th bit.
- Throughput: one bit per cycle sustained when byte_ready is held high. There are no bubbles between words.
- While byte_valid && !byte_ready, byte_out and byte_valid remain stable.
- Stall: bit_ready drops only when cnt == WIDTH-1, byte_valid == 1 and byte_ready == 0. The source must hold bit_in and frame_start stable until bit_ready returns.

## Test plan
- WIDTH=8, MSB_FIRST=0, byte_ready=1: bits 1,0,1,1,0,0,0,1 on consecutive cycles -> byte_valid pulses for one cycle after the 8th bit with byte_out=8'h8D.
- MSB_FIRST=1, same stream -> byte_out=8'hB1. Then 16 back-to-back bits forming 8'h00 and 8'hFF -> two valid cycles 8 cycles apart, bit_ready constantly 1.
- byte_ready=0, stream two words 8'hA5 then 8'h3C:
  - 8'hA5 is held stable and bit_ready=0 at the 8th bit of the second word.
  - Raising byte_ready for one cycle accepts 8'hA5 and the 8th bit in the same edge.
  - The next cycle shows byte_out=8'h3C, byte_valid=1.
- Three bits, then a frame_start bit, then 7 bits -> drop_cnt=1 and the word is built from the frame_start bit onward. frame_start on an aligned word boundary -> drop_cnt unchanged.
- 300 aborted partial words -> drop_cnt saturates at 255.
- rst asserted after 5 bits with a word pending -> next cycle byte_valid=0, byte_out=0, drop_cnt=0. The next 8 bits form a clean word.

Source files
------------

// File: rtl/serial_byte_assembler.sv
// rtl/serial_byte_assembler.sv - bit-serial to WIDTH-bit word assembler with valid/ready output register
module serial_byte_assembler #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic             bit_ready,
    output logic [WIDTH-1:0] byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [7:0]       drop_cnt
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    pos;
    logic [CW-1:0]    idx;
    logic             bit_acc;
    logic             word_acc;
    logic             done;

    // frame_start restarts the word, so the incoming bit lands in slot 0
    always_comb begin
        bit_ready = !rst && (cnt != LAST || !byte_valid || byte_ready);
        bit_acc   = bit_valid && bit_ready;
        word_acc  = byte_valid && byte_ready;
        pos       = frame_start ? '0 : cnt;
        idx       = MSB_FIRST ? LAST - pos : pos;
        done      = bit_acc && (pos == LAST);
        sr_next   = frame_start ? '0 : sr;
        sr_next[idx] = bit_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            if (bit_acc) begin
                if (frame_start && cnt != '0 && drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
                if (done) begin
                    byte_out   <= sr_next;
                    byte_valid <= 1'b1;
                    sr         <= '0;
                    cnt        <= '0;
                end else begin
                    sr  <= sr_next;
                    cnt <= pos + 1'b1;
                end
            end
            if (word_acc && !done) begin
                byte_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_byte_assembler.sv
// tb/tb_serial_byte_assembler.sv - randomized and directed bench for serial_byte_assembler
module tb_serial_byte_assembler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       byte_ready = 1'b0;
    logic       ready0, ready1, valid0, valid1;
    logic [7:0] out0, out1, drop0, drop1;

    always #5 clk = ~clk;

    serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .bit_ready(ready0), .byte_out(out0),
        .byte_valid(valid0), .byte_ready(byte_ready), .drop_cnt(drop0)
    );

    serial_byte_assembler #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .bit_ready(ready1), .byte_out(out1),
        .byte_valid(valid1), .byte_ready(byte_ready), .drop_cnt(drop1)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: bits of the word in progress, in arrival order
    bit         mq[$];
    logic [7:0] m_lsb = 8'h00;
    logic [7:0] m_msb = 8'h00;
    bit         m_valid = 1'b0;
    int         m_drop = 0;

    logic       s_ready, s_valid, last_acc;
    logic [7:0] s_out0, s_out1, s_drop;
    int         cyc = 0, vcount = 0, rlow = 0, first_v = 0, last_v = 0;

    task automatic cycle();
        bit exp_ready, acc, wacc;
        @(negedge clk);
        cyc++;
        exp_ready = !rst && (mq.size() != 7 || !m_valid || byte_ready);
        s_ready = ready0; s_valid = valid0; s_out0 = out0; s_out1 = out1; s_drop = drop0;
        if (valid0 === 1'b1) begin
            if (vcount == 0) first_v = cyc;
            last_v = cyc;
            vcount++;
        end
        if (ready0 !== 1'b1) rlow++;
        check("bit_ready", ready0, exp_ready);
        check("bit_ready_msb", ready1, exp_ready);
        check("byte_valid", valid0, m_valid);
        check("byte_valid_msb", valid1, m_valid);
        check("byte_out_lsb", out0, m_lsb);
        check("byte_out_msb", out1, m_msb);
        check("drop_cnt", drop0, m_drop);
        check("drop_cnt_msb", drop1, m_drop);
        acc  = bit_valid && exp_ready;
        wacc = m_valid && byte_ready;
        last_acc = acc;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_lsb = 8'h00; m_msb = 8'h00; m_valid = 1'b0; m_drop = 0;
        end else begin
            if (acc) begin
                if (frame_start) begin
                    if (mq.size() != 0 && m_drop < 255) m_drop++;
                    mq.delete();
                end
                mq.push_back(bit_in);
            end
            if (mq.size() == 8) begin
                foreach (mq[i]) begin
                    m_lsb[i]   = mq[i];
                    m_msb[7-i] = mq[i];
                end
                m_valid = 1'b1;
                mq.delete();
            end else if (wacc) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic send(input bit b, input bit fs);
        bit got = 1'b0;
        bit_in = b; frame_start = fs; bit_valid = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            cycle();
            got = last_acc;
        end
        if (!got) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [7:0] w, input bit fs);
        for (int i = 0; i < 8; i++) send(w[i], fs && i == 0);
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0; frame_start = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; bit_valid = 1'b0; frame_start = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    logic [7:0] pat;

    initial begin
        @(posedge clk); #1;
        cycle();
        rst = 1'b0;
        idle(1);
        check("reset_valid", s_valid, 1'b0);
        check("reset_out", s_out0, 8'h00);

        byte_ready = 1'b1;
        pat = 8'h8D;
        for (int i = 0; i < 8; i++) send(pat[i], 1'b0);
        idle(1);
        check("t1_valid", s_valid, 1'b1);
        check("t1_out_lsb", s_out0, 8'h8D);
        check("t1_out_msb", s_out1, 8'hB1);
        idle(1);
        check("t1_pulse", s_valid, 1'b0);

        vcount = 0; rlow = 0;
        for (int i = 0; i < 16; i++) send(i >= 8, 1'b0);
        idle(1);
        check("b2b_valid_cycles", vcount, 2);
        check("b2b_spacing", last_v - first_v, 8);
        check("b2b_ready_low", rlow, 0);
        check("b2b_last_msb", s_out1, 8'hFF);

        byte_ready = 1'b0;
        pat = 8'h3C;
        send_word(8'hA5, 1'b0);
        for (int i = 0; i < 7; i++) send(pat[i], 1'b0);
        bit_in = pat[7]; bit_valid = 1'b1;
        cycle(); cycle();
        check("stall_ready", s_ready, 1'b0);
        check("stall_hold_out", s_out0, 8'hA5);
        check("stall_hold_valid", s_valid, 1'b1);
        byte_ready = 1'b1;
        cycle();
        check("drain_accept", last_acc, 1'b1);
        byte_ready = 1'b0;
        idle(1);
        check("drain_out", s_out0, 8'h3C);
        check("drain_valid", s_valid, 1'b1);
        byte_ready = 1'b1;
        idle(2);

        do_reset();
        pat = 8'h5A;
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
        send_word(pat, 1'b1);
        idle(1);
        check("fs_drop", s_drop, 8'd1);
        check("fs_word", s_out0, 8'h5A);
        send_word(8'hC3, 1'b1);
        idle(1);
        check("fs_aligned_drop", s_drop, 8'd1);
        check("fs_aligned_word", s_out0, 8'hC3);

        do_reset();
        for (int i = 0; i < 301; i++) send(1'($urandom_range(0, 1)), 1'b1);
        idle(1);
        check("drop_saturate", s_drop, 8'd255);

        byte_ready = 1'b0;
        send(1'b0, 1'b1);
        for (int i = 1; i < 8; i++) send(1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 5; i++) send(1'($urandom_range(0, 1)), 1'b0);
        rst = 1'b1; bit_valid = 1'b1;
        cycle();
        check("rst_ready_low", s_ready, 1'b0);
        rst = 1'b0;
        idle(1);
        check("rst_valid", s_valid, 1'b0);
        check("rst_out", s_out0, 8'h00);
        check("rst_drop", s_drop, 8'd0);
        byte_ready = 1'b1;
        send_word(8'hE7, 1'b0);
        idle(1);
        check("rst_clean_word", s_out0, 8'hE7);
        check("rst_clean_valid", s_valid, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            if (!(bit_valid && !last_acc && !rst)) begin
                bit_valid   = ($urandom_range(0, 3) != 0);
                bit_in      = 1'($urandom_range(0, 1));
                frame_start = ($urandom_range(0, 15) == 0);
            end
            byte_ready = ($urandom_range(0, 2) != 0);
            rst        = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
